// File: rtl/circular_fifo_rev2.sv
// Wrap-around single-clock FIFO with thresholds, sticky error flags and a registered read port.
// Define CIRCULAR_FIFO_FWFT_EN for a first-word fall-through (zero-latency) read port.
module circular_fifo_rev2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 2,
    parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
    parameter int AFULL_THRESH  = RAM_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_cs,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_cs,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   data_counter_out,
    output logic [ADDR_WIDTH-1:0] wr_pointer_out,
    output logic [ADDR_WIDTH-1:0] rd_pointer_out
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  wr_req, rd_req, wr_acc, rd_acc;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (int'(count_q) >= AFULL_THRESH);
    assign almost_empty = (int'(count_q) <= AEMPTY_THRESH);

    assign wr_req = wr_cs & wr_en;
    assign rd_req = rd_cs & rd_en;
    assign rd_acc = rd_req & ~empty;
    // A read in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign wr_acc = wr_req & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
        else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
        // Setting an error flag takes priority over clearing it.
        ovf_d = (ovf_q & ~clr_err) | (wr_req & ~wr_acc);
        udf_d = (udf_q & ~clr_err) | (rd_req & empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef CIRCULAR_FIFO_FWFT_EN
    assign data_out   = mem_q[rd_ptr_q];
    assign data_valid = ~empty;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dvld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
            dvld_q <= 1'b0;
        end else begin
            dvld_q <= rd_acc;
            if (rd_acc) dout_q <= mem_q[rd_ptr_q];
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dvld_q;
`endif

    assign overflow         = ovf_q;
    assign underflow        = udf_q;
    assign data_counter_out = count_q;
    assign wr_pointer_out   = wr_ptr_q;
    assign rd_pointer_out   = rd_ptr_q;
endmodule

// File: tb/tb_circular_fifo_rev2.sv
// Directed bench for circular_fifo_rev2: expected read words are queued at issue time
// and a negedge monitor pops and compares them whenever data_valid is seen.
module tb_circular_fifo_rev2;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_cs = 0, wr_en = 0, rd_cs = 0, rd_en = 0, clr_err = 0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] data_counter_out;
    logic [1:0] wr_pointer_out, rd_pointer_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] expq [$];

    circular_fifo_rev2 #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
        .rd_cs(rd_cs), .rd_en(rd_en), .clr_err(clr_err),
        .data_out(data_out), .data_valid(data_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow),
        .data_counter_out(data_counter_out),
        .wr_pointer_out(wr_pointer_out), .rd_pointer_out(rd_pointer_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1ns after the rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_cs = w; wr_en = w; data_in = d; rd_cs = r; rd_en = r; clr_err = c;
`ifdef CIRCULAR_FIFO_FWFT_EN
        if (r && expq.size() > 0) begin
            #1;
            check("fwft_rd", {24'h0, data_out}, {24'h0, expq.pop_front()});
        end
`endif
        @(posedge clk); #1;
        wr_cs = 0; wr_en = 0; rd_cs = 0; rd_en = 0; clr_err = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] exp);
        expq.push_back(exp);
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

`ifndef CIRCULAR_FIFO_FWFT_EN
    always @(negedge clk) begin
        if (reset_n && data_valid) begin
            if (expq.size() == 0) check("unexpected_valid", {24'h0, data_out}, 32'hFFFF_FFFF);
            else                  check("rd_data", {24'h0, data_out}, {24'h0, expq.pop_front()});
        end
    end
`endif

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", data_counter_out, 0);
        check("rst_flags", {full, empty, almost_full, almost_empty, overflow, underflow, data_valid},
              7'b0101000);
        check("rst_ptrs", {wr_pointer_out, rd_pointer_out}, 0);
`ifndef CIRCULAR_FIFO_FWFT_EN
        check("rst_dout", data_out, 0);
`endif
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Chip select gates the write.
        wr_cs = 0; wr_en = 1; data_in = 8'hEE;
        @(posedge clk); #1; wr_en = 0;
        check("cs_gate", data_counter_out, 0);

        wr(8'h11);
        check("c1_aempty", {almost_empty, empty}, 2'b10);
`ifdef CIRCULAR_FIFO_FWFT_EN
        check("fwft_show", {data_valid, data_out}, {1'b1, 8'h11});
`endif
        wr(8'h22);
        check("c2_thresh", {almost_empty, almost_full}, 2'b00);
        wr(8'h33);
        check("c3_thresh", {almost_full, full}, 2'b10);
        wr(8'h44);
        check("fill_count", data_counter_out, 4);
        check("fill_full", {full, wr_pointer_out}, {1'b1, 2'd0});

        wr(8'h55);
        check("ovf_set", {overflow, data_counter_out}, {1'b1, 3'd4});
        step(1'b1, 8'h55, 1'b0, 1'b1);
        check("ovf_set_wins", overflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", overflow, 0);

        // Full: write+read both accepted.
        expq.push_back(8'h11);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        check("full_rw_count", {data_counter_out, overflow}, {3'd4, 1'b0});
        check("full_rw_ptrs", {wr_pointer_out, rd_pointer_out}, {2'd1, 2'd1});

        rd(8'h22); rd(8'h33); rd(8'h44); rd(8'h66);
        check("drain_empty", {empty, data_counter_out, rd_pointer_out}, {1'b1, 3'd0, 2'd1});
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_set", {underflow, data_counter_out}, {1'b1, 3'd0});
`ifndef CIRCULAR_FIFO_FWFT_EN
        check("udf_hold", {data_valid, data_out}, {1'b0, 8'h66});
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("udf_clr", underflow, 0);

        // Wrap-around, write/read one apart; each pair runs at count==1.
        wr(8'hA0);
        for (int i = 1; i < 6; i++) begin
            expq.push_back(8'hA0 + 8'(i - 1));
            step(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
            check("wrap_count", data_counter_out, 1);
        end
        rd(8'hA5);
        check("wrap_ptrs", {wr_pointer_out, rd_pointer_out, empty}, {2'd3, 2'd3, 1'b1});

        // Async reset mid-burst at count 2.
        wr(8'hC1); wr(8'hC2);
        check("pre_rst_count", data_counter_out, 2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_count", data_counter_out, 0);
        check("mid_rst_state", {empty, almost_empty, full, wr_pointer_out, rd_pointer_out, data_valid},
              {1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0});
`ifndef CIRCULAR_FIFO_FWFT_EN
        check("mid_rst_dout", data_out, 0);
`endif
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        wr(8'h77);
        rd(8'h77);
        check("post_rst", {empty, wr_pointer_out, rd_pointer_out}, {1'b1, 2'd1, 2'd1});

        @(negedge clk); @(negedge clk);
        check("sb_drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
